// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with write-through bypass and pending-write scoreboard
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_addr,
  output logic                  iss_stall,
  input  logic [ADDR_W-1:0]     dbg_addr,
  output logic [DATA_W-1:0]     dbg_data
);
  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] wval [NREGS];
  logic [NREGS-1:0]  pending, wen;
  logic              iss_ok;
  // Ascending port scan: the highest-index write to a register overrides lower ones.
  always_comb begin
    wen = '0;
    for (int r = 0; r < NREGS; r++) wval[r] = '0;
    for (int j = 0; j < NWR; j++)
      if (wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] != '0) begin
        wen[wr_addr[j*ADDR_W +: ADDR_W]]  = 1'b1;
        wval[wr_addr[j*ADDR_W +: ADDR_W]] = wr_data[j*DATA_W +: DATA_W];
      end
  end
  genvar k;
  generate
    for (k = 0; k < NRD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      assign ra = rd_addr[k*ADDR_W +: ADDR_W];
      assign rd_data[k*DATA_W +: DATA_W] = ra == '0 ? '0 : wen[ra] ? wval[ra] : regs[ra];
      assign rd_busy[k] = ra != '0 && pending[ra] && !wen[ra];
    end
  endgenerate
  assign iss_stall = iss_en && iss_addr != '0 && pending[iss_addr] && !wen[iss_addr];
  assign iss_ok    = iss_en && iss_addr != '0 && !iss_stall;
  assign dbg_data  = dbg_addr == '0 ? '0 : regs[dbg_addr];
  // Issue takes priority over a same-cycle write so the new producer stays tracked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      pending <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (wen[r]) regs[r] <= wval[r];
        pending[r] <= (iss_ok && iss_addr == ADDR_W'(r)) ? 1'b1 : wen[r] ? 1'b0 : pending[r];
      end
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: table-driven vectors plus hand-written reset sequence for regfile_sb
module tb_regfile_sb;
  logic        clk = 0;
  logic        rst = 0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en = '0;
  logic [9:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic        iss_en = 0;
  logic [4:0]  iss_addr = '0;
  logic        iss_stall;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;
  int errors = 0;
  int checks = 0;

  regfile_sb dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .iss_stall(iss_stall), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [4:0]  ra0, ra1;
    logic        ie;
    logic [4:0]  ia, da;
    logic [31:0] e0, e1;
    logic [1:0]  eb;
    logic        es;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0,
                              logic [4:0] wa1, logic [31:0] wd1, logic [4:0] ra0, logic [4:0] ra1,
                              logic ie, logic [4:0] ia, logic [4:0] da, logic [31:0] e0,
                              logic [31:0] e1, logic [1:0] eb, logic es, logic [31:0] ed);
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.ra0 = ra0; v.ra1 = ra1; v.ie = ie; v.ia = ia; v.da = da;
    v.e0 = e0; v.e1 = e1; v.eb = eb; v.es = es; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    wr_en    = v.we;
    wr_addr  = {v.wa1, v.wa0};
    wr_data  = {v.wd1, v.wd0};
    rd_addr  = {v.ra1, v.ra0};
    iss_en   = v.ie;
    iss_addr = v.ia;
    dbg_addr = v.da;
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, " rd0"}, rd_data[31:0], v.e0);
    chk({tag, " rd1"}, rd_data[63:32], v.e1);
    chk({tag, " busy"}, {30'd0, rd_busy}, {30'd0, v.eb});
    chk({tag, " stall"}, {31'd0, iss_stall}, {31'd0, v.es});
    chk({tag, " dbg"}, dbg_data, v.ed);
  endtask

  initial begin
    vec_t idle;
    idle = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    //            we     wa0 wd0           wa1 wd1           ra0 ra1 ie ia da  e0            e1            eb     es ed
    vecs[0]  = mk(2'b01, 7,  32'hDEADBEEF, 0,  0,            0,  7,  0, 0, 7,  0,            32'hDEADBEEF, 2'b00, 0, 0);
    vecs[1]  = mk(2'b00, 0,  0,            0,  0,            7,  0,  0, 0, 7,  32'hDEADBEEF, 0,            2'b00, 0, 32'hDEADBEEF);
    vecs[2]  = mk(2'b11, 3,  32'h11,       3,  32'h22,       3,  7,  0, 0, 3,  32'h22,       32'hDEADBEEF, 2'b00, 0, 0);
    vecs[3]  = mk(2'b00, 0,  0,            0,  0,            3,  7,  0, 0, 3,  32'h22,       32'hDEADBEEF, 2'b00, 0, 32'h22);
    vecs[4]  = mk(2'b11, 0,  32'hFFFFFFFF, 0,  32'hFFFFFFFF, 0,  0,  1, 0, 0,  0,            0,            2'b00, 0, 0);
    vecs[5]  = mk(2'b00, 0,  0,            0,  0,            0,  0,  0, 0, 0,  0,            0,            2'b00, 0, 0);
    vecs[6]  = mk(2'b00, 0,  0,            0,  0,            9,  3,  1, 9, 9,  0,            32'h22,       2'b00, 0, 0);
    vecs[7]  = mk(2'b00, 0,  0,            0,  0,            9,  9,  1, 9, 9,  0,            0,            2'b11, 1, 0);
    vecs[8]  = mk(2'b00, 0,  0,            0,  0,            9,  0,  0, 0, 9,  0,            0,            2'b01, 0, 0);
    vecs[9]  = mk(2'b10, 0,  0,            9,  32'h55,       9,  9,  0, 0, 9,  32'h55,       32'h55,       2'b00, 0, 0);
    vecs[10] = mk(2'b00, 0,  0,            0,  0,            9,  7,  0, 0, 9,  32'h55,       32'hDEADBEEF, 2'b00, 0, 32'h55);
    vecs[11] = mk(2'b00, 0,  0,            0,  0,            4,  9,  1, 4, 4,  0,            32'h55,       2'b00, 0, 0);
    vecs[12] = mk(2'b01, 4,  32'h77,       0,  0,            4,  0,  1, 4, 4,  32'h77,       0,            2'b00, 0, 0);
    vecs[13] = mk(2'b00, 0,  0,            0,  0,            4,  4,  0, 0, 4,  32'h77,       32'h77,       2'b11, 0, 32'h77);
    vecs[14] = mk(2'b11, 4,  32'h88,       4,  32'h99,       4,  3,  0, 0, 4,  32'h99,       32'h22,       2'b00, 0, 32'h77);
    vecs[15] = mk(2'b00, 0,  0,            0,  0,            4,  9,  1, 4, 4,  32'h99,       32'h55,       2'b00, 0, 32'h99);
    vecs[16] = mk(2'b00, 0,  0,            0,  0,            4,  0,  0, 0, 4,  32'h99,       0,            2'b01, 0, 32'h99);
    vecs[17] = mk(2'b11, 4,  32'h12345678, 10, 32'hABCD,     4,  10, 0, 0, 10, 32'h12345678, 32'hABCD,     2'b00, 0, 0);
    vecs[18] = mk(2'b00, 0,  0,            0,  0,            4,  10, 0, 0, 10, 32'h12345678, 32'hABCD,     2'b00, 0, 32'hABCD);

    #12;
    chk_all("reset", idle);
    rst = 1;
    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      drive(vecs[i]);
      #2;
      chk_all($sformatf("v%0d", i), vecs[i]);
    end

    // Preload r5 with a value and a pending producer, then reset between edges.
    @(posedge clk); #1;
    drive(mk(2'b01, 5, 32'h1234, 0, 0, 0, 0, 1, 5, 0, 0, 0, 2'b00, 0, 0));
    @(posedge clk); #1;
    drive(mk(2'b00, 0, 0, 0, 0, 5, 0, 0, 0, 5, 0, 0, 2'b00, 0, 0));
    #1;
    chk("pre r5 rd0", rd_data[31:0], 32'h1234);
    chk("pre r5 busy", {31'd0, rd_busy[0]}, 32'd1);
    chk("pre r5 dbg", dbg_data, 32'h1234);
    drive(mk(2'b01, 6, 32'hAAAA, 0, 0, 5, 0, 1, 6, 5, 0, 0, 2'b00, 0, 0));
    #1 rst = 0;
    #1;
    chk("async r5 rd0", rd_data[31:0], 32'h0);
    chk("async r5 busy", {31'd0, rd_busy[0]}, 32'd0);
    chk("async r5 dbg", dbg_data, 32'h0);
    @(posedge clk); #2;
    drive(mk(2'b00, 0, 0, 0, 0, 5, 6, 0, 0, 6, 0, 0, 2'b00, 0, 0));
    #1 rst = 1;
    @(posedge clk); #1;
    chk_all("post reset", mk(2'b00, 0, 0, 0, 0, 5, 6, 0, 0, 6, 0, 0, 2'b00, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port integer register file with built-in write-bypass and a per-register pending-write scoreboard, the successor of the pipeline's 2-read/1-write register file. Sits between the decode stage, which reads operands and issues destinations, and the writeback stage(s), which retire results. Decode stalls on the busy and stall flags instead of a separate hazard unit. Register 0 is hardwired to zero.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- NREGS, 32, number of registers (power of two, ≥ 2); ADDR_W = $clog2(NREGS)
- NRD, 2, number of read ports (≥ 1)
- NWR, 2, number of write ports (≥ 1)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- rd_addr  in  NRD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
- rd_data  out  NRD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
- rd_busy  out  NRD  port k operand still awaits an outstanding write
- wr_en  in  NWR  write enables
- wr_addr  in  NWR*ADDR_W  write addresses
- wr_data  in  NWR*DATA_W  write data
- iss_en  in  1  decode issues an instruction writing iss_addr
- iss_addr  in  ADDR_W  destination being issued
- iss_stall  out  1  issue refused (destination already pending)
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  debug read data (no bypass)

## Operation
- Storage: NREGS × DATA_W flops plus an NREGS-bit pending vector. Entry 0 is never written and never pending.
- Effective write to r: wr_en[j] && wr_addr[j]==r && r!=0. Same cycle, several ports to the same r: the highest index j wins.
- Reads are combinational. rd_data[k]:
  - 0 if rd_addr[k]==0
  - else the winning wr_data if an effective write targets rd_addr[k] this cycle (write-through bypass)
  - else the stored value
- rd_busy[k] = pending[rd_addr[k]] && no effective write to rd_addr[k] this cycle. Always 0 for address 0.
- iss_stall = iss_en && iss_addr!=0 && pending[iss_addr] && no effective write to iss_addr this cycle. Always 0 when iss_en=0.
- Scoreboard update at each rising edge, per r:
  - an accepted issue (iss_en && iss_addr==r && r!=0 && !iss_stall) sets pending[r]
  - otherwise any effective write to r clears it
  - issue and write to the same r in the same cycle: the write retires the old producer, the issue marks the new one, and pending[r] ends at 1
- A write to a non-pending register is legal: it updates data and pending stays 0.
- Only one outstanding producer per register. Decode holds the instruction while iss_stall=1.
- dbg_data = stored value of dbg_addr (0 for address 0), ignoring same-cycle writes.

## Timing
- Reset (rst=0, asynchronous): all registers become 0 and all pending bits become 0 immediately. Outputs then follow from the combinational rules: rd_data=0, rd_busy=0, iss_stall=0, dbg_data=0.
- While rst=0, writes and issues are ignored. Writes and issues resume at the first rising edge after rst returns to 1.
- Write latency: 0 cycles to the read ports (bypass), 1 edge to storage and dbg_data.
- Pending latency: rd_busy rises the cycle after the accepted issue. It falls combinationally in the cycle the matching write is presented.
- Reset asserted mid-cycle discards any in-flight write or issue. No partial update.

## Test plan
- Reset: preload r5=0x1234 and pending r5, pulse rst=0 asynchronously between edges -> all rd_data=0, rd_busy=0 and dbg_data(r5)=0 immediately.
- Bypass: wr_en[0]=1, wr_addr r7, data 0xDEADBEEF, rd_addr[1]=r7 in the same cycle -> rd_data[1]=0xDEADBEEF that cycle; dbg_data(r7) reads 0xDEADBEEF after the edge.
- Write conflict: port0 writes r3=0x11 and port1 writes r3=0x22 in the same cycle -> bypass reads 0x22 and stored r3=0x22.
- x0: write 0xFFFFFFFF to r0 and issue r0 -> rd_data for r0 stays 0, rd_busy=0, iss_stall=0.
- Scoreboard: issue r9 -> next cycle rd_busy=1 for r9; a second issue of r9 -> iss_stall=1 and pending unchanged; port1 writes r9=0x55 -> rd_busy=0 and rd_data=0x55 in that cycle, and pending clears after the edge.
- Simultaneous: r4 pending, issue r4 while port0 writes r4=0x77 -> iss_stall=0, bypass reads 0x77, and r4 stays pending after the edge (rd_busy=1 next cycle).
